// File: rtl/divu_hilo_unit_if.sv
// Purpose: bundles the DIVU issue, HI/LO result and hazard-stall signals of divu_hilo_unit.
// Latency: none; this is wiring only.
// Backpressure: none here; the stall output asks ID to hold MFHI/MFLO while a divide is in flight.
interface divu_hilo_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             rd_hilo;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             div_by_zero;
    logic             stall;

    // Pipeline side: issues divides and reads HI/LO.
    modport master (
        output start, dividend, divisor, rd_hilo,
        input  busy, done, hi, lo, div_by_zero, stall
    );

    // Divider side.
    modport slave (
        input  start, dividend, divisor, rd_hilo,
        output busy, done, hi, lo, div_by_zero, stall
    );
endinterface

// File: rtl/divu_hilo_unit.sv
// Purpose: restoring unsigned divider that writes the remainder to HI and the quotient to LO.
// Latency: WIDTH clocks from the start edge to the done pulse; 1 clock when the divisor is 0.
// Backpressure: a start during RUN/DZERO is dropped; stall holds MFHI/MFLO in ID while busy or starting.
module divu_hilo_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    divu_hilo_unit_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DZERO = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;      // holds the latched dividend until bits shift out
    logic [WIDTH-1:0] dvs;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic             dbz_q;

    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] rem_step;
    logic [WIDTH-1:0] quo_step;
    logic             accept;
    logic             last_step;
    logic             busy_w;
    logic             done_w;

    // A new divide is only taken when the unit is not already working on one.
    assign accept    = bus.start && ((state == IDLE) || (state == DONE));
    assign last_step = (state == RUN) && (cnt == CNT_W'(1));

    // One restoring step. The partial remainder is always below the divisor, so
    // the shifted remainder minus the divisor fits in WIDTH+1 bits with the MSB
    // acting as the sign, even when the divisor has its top bit set.
    always_comb begin
        trial = {rem, quo[WIDTH-1]} - {1'b0, dvs};
        if (!trial[WIDTH]) begin
            rem_step = trial[WIDTH-1:0];
            quo_step = {quo[WIDTH-2:0], 1'b1};
        end else begin
            rem_step = {rem[WIDTH-2:0], quo[WIDTH-1]};
            quo_step = {quo[WIDTH-2:0], 1'b0};
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nxt = (bus.divisor != '0) ? RUN : DZERO;
                end
            end
            RUN: begin
                if (last_step) begin
                    state_nxt = DONE;
                end
            end
            DZERO: begin
                state_nxt = DONE;
            end
            DONE: begin
                if (bus.start) begin
                    state_nxt = (bus.divisor != '0) ? RUN : DZERO;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Status outputs decoded from the state; stall also covers the issue cycle.
    always_comb begin
        busy_w    = (state == RUN);
        done_w    = (state == DONE);
        bus.stall = bus.rd_hilo && (busy_w || bus.start);
    end

    assign bus.busy        = busy_w;
    assign bus.done        = done_w;
    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;
    assign bus.div_by_zero = dbz_q;

    // Operand latch, iteration datapath and HI/LO update on completion.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt   <= '0;
            rem   <= '0;
            quo   <= '0;
            dvs   <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
            dbz_q <= 1'b0;
        end else begin
            if (accept) begin
                quo <= bus.dividend;
                dvs <= bus.divisor;
                rem <= '0;
                cnt <= CNT_W'(WIDTH);
            end else if (state == RUN) begin
                rem <= rem_step;
                quo <= quo_step;
                cnt <= cnt - CNT_W'(1);
                if (last_step) begin
                    hi_q  <= rem_step;
                    lo_q  <= quo_step;
                    dbz_q <= 1'b0;
                end
            end else if (state == DZERO) begin
                hi_q  <= quo;
                lo_q  <= '1;
                dbz_q <= 1'b1;
            end
        end
    end

endmodule
